// File: rtl/conv_mul_arb_pkg.sv
// Shared widths, pipeline stage record and saturation helper for conv_mul_arbiter.
package conv_mul_arb_pkg;

    localparam int A_W      = 16;
    localparam int B_W      = 12;
    localparam int P_W      = 16;
    localparam int FULL_W   = 28;
    localparam int ID_MAX_W = 3;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
        logic [A_W-1:0]      a;
        logic [B_W-1:0]      b;
        logic [FULL_W-1:0]   prod;
    } stage_t;

    // Clamp a full-width signed product into the 16-bit result range.
    function automatic logic [P_W-1:0] sat16(input logic [FULL_W-1:0] full);
        if (full[FULL_W-1:P_W-1] == '0 || full[FULL_W-1:P_W-1] == '1)
            return full[P_W-1:0];
        else if (full[FULL_W-1])
            return {1'b1, {(P_W-1){1'b0}}};
        else
            return {1'b0, {(P_W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/conv_mul_arb_rr.sv
// Round-robin grant: first requester at or above ptr, with wrap; combinational.
// Zero latency; en low forces an all-zero grant.
module conv_mul_arb_rr
    import conv_mul_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (en && !found && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_mul_arbiter.sv
// Shares one signed 16x12 multiplier between NUM_REQ requesters, round-robin, one grant per cycle.
// Latency PIPE_STAGES cycles grant-to-result; a stalled result freezes the whole pipe and all grants.
// CONV_MUL_ARB_SAT_EN selects saturating instead of wrapping 16-bit results.
module conv_mul_arbiter
    import conv_mul_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int PIPE_STAGES = 2,
    parameter int ID_W        = 2
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ID_W-1:0]        res_id,
    output logic [P_W-1:0]         res_data,
    output logic                   busy
);

    localparam int LAST = PIPE_STAGES - 1;

    stage_t                    st [PIPE_STAGES];
    logic [ID_W-1:0]           ptr;
    logic [ID_W-1:0]           gnt_idx;
    logic [NUM_REQ-1:0]        gnt;
    logic                      stall;
    logic                      xfer;
    logic [A_W-1:0]            a_arr [NUM_REQ];
    logic [B_W-1:0]            b_arr [NUM_REQ];
    logic signed [FULL_W-1:0]  p0;
    logic signed [FULL_W-1:0]  out_full;
    logic                      busy_c;
    logic                      unused_bits;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[A_W*i +: A_W];
        assign b_arr[i] = req_b[B_W*i +: B_W];
    end

    assign stall = st[LAST].valid & ~res_ready;

    conv_mul_arb_rr #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_rr (
        .req (req_valid),
        .ptr (ptr),
        .en  (~stall),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;

    // The single multiplier sits between stage 0 and stage 1.
    assign p0 = $signed(st[0].a) * $signed(st[0].b);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ptr <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) st[i] <= '0;
        end else if (!stall) begin
            st[0].valid <= xfer;
            st[0].id    <= ID_MAX_W'(gnt_idx);
            st[0].a     <= a_arr[gnt_idx];
            st[0].b     <= b_arr[gnt_idx];
            st[0].prod  <= '0;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                st[i] <= st[i-1];
                if (i == 1) st[i].prod <= p0;
            end
            if (xfer) ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    if (PIPE_STAGES == 1) begin : g_p1
        assign out_full = p0;
    end else begin : g_pn
        assign out_full = st[LAST].prod;
    end

`ifdef CONV_MUL_ARB_SAT_EN
    assign res_data = sat16(out_full);
`else
    assign res_data = out_full[P_W-1:0];
`endif

    assign res_valid = st[LAST].valid;
    assign res_id    = st[LAST].id[ID_W-1:0];

    always_comb begin
        busy_c      = 1'b0;
        unused_bits = ^out_full;
        for (int i = 0; i < PIPE_STAGES; i++) begin
            busy_c      = busy_c | st[i].valid;
            unused_bits = unused_bits ^ (^st[i]);
        end
    end

    assign busy = busy_c;

endmodule

// File: tb/tb_conv_mul_arbiter.sv
// Bench for conv_mul_arbiter: per-cycle comparison against a queue-based model plus directed literal checks.
`timescale 1ns/1ps
module tb_conv_mul_arbiter;

    localparam int NR = 4;
    localparam int PS = 2;
    localparam int IW = 2;

    logic            ap_clk = 1'b0;
    logic            ap_rst = 1'b1;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*16-1:0] req_a;
    logic [NR*12-1:0] req_b;
    logic            res_valid;
    logic            res_ready;
    logic [IW-1:0]   res_id;
    logic [15:0]     res_data;
    logic            busy;

    conv_mul_arbiter #(
        .NUM_REQ     (NR),
        .PIPE_STAGES (PS),
        .ID_W        (IW)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_prod(input int a, input int b);
        int f;
        f = a * b;
`ifdef CONV_MUL_ARB_SAT_EN
        if (f > 32767) f = 32767;
        else if (f < -32768) f = -32768;
`endif
        return f[15:0];
    endfunction

    function automatic int op_a(input int i);
        return int'($signed(req_a[16*i +: 16]));
    endfunction

    function automatic int op_b(input int i);
        return int'($signed(req_b[12*i +: 12]));
    endfunction

    // Model: in-flight slots (bubbles included) with the output at the last slot.
    bit          mv  [PS];
    int          mid [PS];
    logic [15:0] md  [PS];
    int          mptr = 0;
    bit          chk_en = 1'b0;
    bit          m_stl, m_busy;
    int          m_g, m_i;
    logic [NR-1:0] m_rdy;

    always @(negedge ap_clk) begin
        if (chk_en) begin
            m_stl  = mv[PS-1] && !res_ready;
            m_busy = 1'b0;
            for (int k = 0; k < PS; k++) m_busy |= mv[k];
            m_g = -1;
            if (!m_stl) begin
                for (int k = 0; k < NR; k++) begin
                    m_i = (mptr + k) % NR;
                    if (m_g < 0 && req_valid[m_i]) m_g = m_i;
                end
            end
            m_rdy = '0;
            if (m_g >= 0) m_rdy[m_g] = 1'b1;
            chk("m_req_ready", 32'(req_ready), 32'(m_rdy));
            chk("m_res_valid", 32'(res_valid), 32'(mv[PS-1]));
            chk("m_busy", 32'(busy), 32'(m_busy));
            if (mv[PS-1]) begin
                chk("m_res_id", 32'(res_id), 32'(mid[PS-1]));
                chk("m_res_data", 32'(res_data), 32'(md[PS-1]));
            end
            if (ap_rst) begin
                for (int k = 0; k < PS; k++) mv[k] = 1'b0;
                mptr = 0;
            end else if (!m_stl) begin
                for (int k = PS - 1; k > 0; k--) begin
                    mv[k]  = mv[k-1];
                    mid[k] = mid[k-1];
                    md[k]  = md[k-1];
                end
                mv[0]  = (m_g >= 0);
                mid[0] = m_g;
                md[0]  = (m_g >= 0) ? exp_prod(op_a(m_g), op_b(m_g)) : 16'h0;
                if (m_g >= 0) mptr = (m_g + 1) % NR;
            end
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge ap_clk);
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[16*i +: 16] = 16'(a);
        req_b[12*i +: 12] = 12'(b);
    endtask

    task automatic do_reset();
        req_valid = '0;
        res_ready = 1'b1;
        ap_rst    = 1'b1;
        tick();
        ap_rst    = 1'b0;
    endtask

    int          ids [$];
    logic [15:0] got [$];
    logic [15:0] sent [$];
    logic [15:0] held;
    int          a2;
    bit          xf;

    initial begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        ap_rst    = 1'b1;
        tick();
        ap_rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        at_neg();
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_res_valid", 32'(res_valid), 32'h0);
        chk("reset_res_id", 32'(res_id), 32'h0);
        chk("reset_res_data", 32'(res_data), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        tick();

        // Single request: 100 * -3 = -300 two cycles later
        set_op(1, 100, -3);
        req_valid = 4'b0010;
        at_neg();
        chk("single_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        at_neg();
        chk("single_busy", 32'(busy), 32'h1);
        tick();
        at_neg();
        chk("single_valid", 32'(res_valid), 32'h1);
        chk("single_id", 32'(res_id), 32'h1);
        chk("single_data", 32'(res_data), 32'h0000FED4);
        tick();

        // Round-robin fairness with all requesters valid
        do_reset();
        for (int i = 0; i < NR; i++) set_op(i, 1000 * i + 123, -(i * 300) - 77);
        req_valid = '1;
        for (int c = 0; c < 12; c++) begin
            at_neg();
            if (c < 8) chk("rr_grant", 32'(req_ready), 32'(1) << (c % 4));
            if (res_valid) ids.push_back(int'(res_id));
            tick();
            if (c == 7) req_valid = '0;
        end
        chk("rr_count", 32'(ids.size()), 32'd8);
        for (int k = 0; k < ids.size(); k++) chk("rr_order", 32'(ids[k]), 32'(k % 4));

        // Backpressure: stream from requester 2, res_ready low for 5 cycles
        do_reset();
        a2 = 50;
        set_op(2, a2, 7);
        req_valid = 4'b0100;
        for (int c = 0; c < 22; c++) begin
            at_neg();
            xf = req_valid[2] && req_ready[2];
            if (res_valid && res_ready) got.push_back(res_data);
            if (c == 4) held = res_data;
            if (c >= 4 && c <= 8) begin
                chk("bp_ready_zero", 32'(req_ready), 32'h0);
                chk("bp_valid_held", 32'(res_valid), 32'h1);
                chk("bp_id_held", 32'(res_id), 32'h2);
                if (c > 4) chk("bp_data_held", 32'(res_data), 32'(held));
            end
            tick();
            if (xf) begin
                sent.push_back(exp_prod(a2, 7));
                a2++;
                set_op(2, a2, 7);
            end
            res_ready = !((c + 1) >= 4 && (c + 1) <= 8);
            if (c == 13) req_valid = '0;
        end
        chk("bp_sent", 32'(sent.size()), 32'd9);
        chk("bp_count", 32'(got.size()), 32'(sent.size()));
        for (int k = 0; k < got.size() && k < sent.size(); k++)
            chk("bp_data", 32'(got[k]), 32'(sent[k]));

        // Wrap versus saturate
        do_reset();
        set_op(0, 32767, 2047);
        req_valid = 4'b0001;
        at_neg();
        tick();
        set_op(0, -32768, 2047);
        at_neg();
        tick();
        req_valid = '0;
        at_neg();
`ifdef CONV_MUL_ARB_SAT_EN
        chk("wrap_pos", 32'(res_data), 32'h7FFF);
`else
        chk("wrap_pos", 32'(res_data), 32'h7801);
`endif
        tick();
        at_neg();
        chk("wrap_neg", 32'(res_data), 32'h8000);
        tick();

        // Reset with two entries in flight
        do_reset();
        set_op(0, 11, 13);
        set_op(1, -21, 5);
        req_valid = 4'b0011;
        res_ready = 1'b0;
        at_neg();
        tick();
        at_neg();
        tick();
        req_valid = '0;
        at_neg();
        chk("mid_busy_pre", 32'(busy), 32'h1);
        chk("mid_stalled", 32'(res_valid), 32'h1);
        tick();
        ap_rst = 1'b1;
        tick();
        ap_rst    = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            at_neg();
            chk("mid_no_res", 32'(res_valid), 32'h0);
            chk("mid_busy", 32'(busy), 32'h0);
            tick();
        end
        req_valid = 4'b1001;
        at_neg();
        chk("mid_ptr0", 32'(req_ready), 32'h1);
        tick();
        at_neg();
        chk("mid_then3", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;

        // Sparse requests with ptr at 1
        do_reset();
        set_op(0, 3, 4);
        set_op(3, -5, 6);
        req_valid = 4'b0001;
        at_neg();
        chk("sparse_first0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b1001;
        at_neg();
        chk("sparse_3", 32'(req_ready), 32'h8);
        tick();
        at_neg();
        chk("sparse_0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
